refresco_display: RTL and testbench
===================================

# refresco_display

Two-digit display refresh and digit-feed stage. It captures a binary value from the Gray decoder and converts it to two BCD digits with a sequential double-dabble converter. It generates the 10 kHz digit-select signal `contador_actualizar` that drives the anode controller, and presents the BCD digit for the active position to the 7-segment decoder.

## Interface
- `ANCHO`, 4, width of the binary input. Legal range is 1..6, so the maximum value of 63 fits in two digits.
- `DIV`, 10000, clock cycles per refresh tick. 100 MHz / 10000 = 10 kHz. Must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `valor`  in  ANCHO  unsigned binary value to display.
- `valido`  in  1  one-cycle strobe; `valor` is valid this cycle.
- `ocupado`  out  1  high while a conversion is in progress; `valido` is ignored while high.
- `contador_actualizar`  out  1  digit select: 0 = units, 1 = tens. Feeds the anode controller.
- `digito`  out  4  BCD digit for the active position. Feeds the 7-segment decoder.

## Operation
- **Prescaler**
  - Counter `pre` counts 0..DIV-1 and wraps to 0.
  - The internal tick is high in the cycle where `pre == DIV-1`.
  - On the tick edge, `contador_actualizar` toggles.
- **Converter FSM** (states INACTIVO, DESPLAZA, FIN)
  - **INACTIVO:** If `valido` is high, load shift register `{bcd[7:0]=0, bin=valor}`, clear step count `n`, and go to DESPLAZA. `ocupado` is registered and goes high on that edge.
  - **DESPLAZA:** Each cycle, add 3 to each BCD nibble ≥ 5, then shift the whole register left by 1 and increment `n`. After ANCHO shifts, go to FIN.
  - **FIN:** Copy `bcd[3:0]` to `unidades` and `bcd[7:4]` to `decenas` atomically. Clear `ocupado` and return to INACTIVO.
- **Dropped strobes:** `valido` seen while `ocupado` is high, or in FIN, is dropped silently. No queueing.
- **Output mux:** `digito = contador_actualizar ? decenas : unidades`. It is combinational from registers only, so it changes on the same edge as the select or the commit.
- **Display stability:** `unidades` and `decenas` hold the last committed value. The display never shows a partial conversion.
- **Reset values:** `contador_actualizar = 0`, `digito = 0`, `ocupado = 0`, `unidades = decenas = 0`, `pre = 0`, FSM in INACTIVO.
- **Reset mid-conversion:** abort the conversion and return to the reset values. The converted value is lost.

## Timing
- **Acceptance:** `valido` is sampled at edge E with `ocupado == 0`.
  - Shifts happen at edges E+1..E+ANCHO.
  - Commit happens at edge E+ANCHO+1.
  - `ocupado` is high from E to E+ANCHO+1. It reads low after E+ANCHO+1.
  - Total latency is ANCHO+2 edges. For ANCHO=4, `digito` shows the new value after edge E+5.
- **Refresh period:** `contador_actualizar` has period 2·DIV cycles. Each digit is shown for exactly DIV cycles.
- **First toggle:** the first toggle after reset occurs at edge DIV.
- **Independence:** the prescaler and the converter are independent. A commit coinciding with a select toggle is legal; `digito` shows the new digit of the new position after that edge.

## Configuration
- Macro: `REFRESCO_BLANK_CEROS_EN`.
- **Defined:** leading-zero blanking. In the tens slot, if `decenas == 0`, `digito = 4'hF`, which is the decoder's blank code. The units slot is never blanked, so value 0 shows "0".
- **Not defined:** the tens slot always shows `decenas`, including 0.

## Structure
- **Shared package `display_pkg`:**
  - converter state encoding (INACTIVO / DESPLAZA / FIN);
  - `BLANK_BCD = 4'hF`;
  - default `DIV_10KHZ = 10000`.
- **Sub-module `conversor_bin_bcd`:** the double-dabble FSM, with ports `clk`, `rst`, `valor`, `valido`, `ocupado`, `unidades`, `decenas`.
- **Top level** holds the prescaler, the select flop and the output mux.
- **Parameter check:** an elaboration-time check fails if ANCHO is outside 1..6.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `contador_actualizar = 0`, `digito = 0`, `ocupado = 0` immediately, with no clock edge.
- **Refresh:** DIV=4, idle → `contador_actualizar` toggles at edges 4, 8, 12. `digito` alternates between the units and tens registers every 4 cycles.
- **Conversion:** ANCHO=4, `valor = 13` with `valido` at edge E.
  - `ocupado` is high E..E+5.
  - After E+5, `digito = 3` in the units slot and `digito = 1` in the tens slot.
  - `valor = 15` gives 5 and 1.
- **Dropped strobe:** `valor = 9` accepted, then `valor = 2` with `valido` at E+2 → display shows 9. The 2 is never shown and `ocupado` is not re-extended.
- **Blanking:** `valor = 7`.
  - With `REFRESCO_BLANK_CEROS_EN`: tens slot `digito = 4'hF`, units slot `digito = 7`.
  - Without the macro: tens slot `digito = 0`.
- **Reset mid-operation:** reset during DESPLAZA after a prior commit of 12 → `ocupado = 0`, display 0/0. The next `valido` with `valor = 6` converts normally to 6.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit display refresh stage.
// Converter state encoding, blank code, default refresh divider, BCD adjust helper.
package display_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } conv_estado_t;

  localparam logic [3:0] BLANK_BCD = 4'hF;
  localparam int DIV_10KHZ = 10000;

  function automatic logic [3:0] ajusta(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/conversor_bin_bcd.sv
// Sequential double-dabble binary to two-digit BCD converter.
// Ports: clk, rst, valor/valido in, ocupado, unidades, decenas out.
module conversor_bin_bcd
  import display_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] valor,
  input  logic             valido,
  output logic             ocupado,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas
);

  localparam int SW = ANCHO + 8;

  conv_estado_t estado, estado_sig;

  logic [SW-1:0] sr;
  logic [SW-1:0] sr_aj;
  logic [2:0]    n;
  logic          ultimo;
  logic          cargar;
  logic          desplazar;
  logic          confirmar;

  assign ultimo = (n == 3'(ANCHO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= INACTIVO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      INACTIVO: if (valido) estado_sig = DESPLAZA;
      DESPLAZA: if (ultimo) estado_sig = FIN;
      FIN:      estado_sig = INACTIVO;
      default:  estado_sig = INACTIVO;
    endcase
  end

  always_comb begin
    cargar    = (estado == INACTIVO) && valido;
    desplazar = (estado == DESPLAZA);
    confirmar = (estado == FIN);
  end

  // BCD nibbles sit just above the binary part of the register
  always_comb begin
    sr_aj = sr;
    sr_aj[ANCHO+3:ANCHO]   = ajusta(sr[ANCHO+3:ANCHO]);
    sr_aj[ANCHO+7:ANCHO+4] = ajusta(sr[ANCHO+7:ANCHO+4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      n        <= '0;
      ocupado  <= 1'b0;
      unidades <= 4'd0;
      decenas  <= 4'd0;
    end else begin
      if (cargar) begin
        sr      <= {8'd0, valor};
        n       <= 3'd0;
        ocupado <= 1'b1;
      end
      if (desplazar) begin
        sr <= {sr_aj[SW-2:0], 1'b0};
        n  <= n + 3'd1;
      end
      if (confirmar) begin
        unidades <= sr[ANCHO+3:ANCHO];
        decenas  <= sr[ANCHO+7:ANCHO+4];
        ocupado  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/refresco_display.sv
// Two-digit display refresh: prescaler, digit select flop, BCD digit mux.
// Ports: clk, rst, valor, valido in; ocupado, contador_actualizar, digito out.
// Optional macro REFRESCO_BLANK_CEROS_EN blanks a zero tens digit.
module refresco_display
  import display_pkg::*;
#(
  parameter int ANCHO = 4,
  parameter int DIV   = DIV_10KHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] valor,
  input  logic             valido,
  output logic             ocupado,
  output logic             contador_actualizar,
  output logic [3:0]       digito
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  if (ANCHO < 1 || ANCHO > 6) begin : g_chk_ancho
    $error("refresco_display: ANCHO must be 1..6");
  end
  if (DIV < 2) begin : g_chk_div
    $error("refresco_display: DIV must be >= 2");
  end

  logic [PW-1:0] pre;
  logic          tick;
  logic [3:0]    unidades;
  logic [3:0]    decenas;

  assign tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre                 <= '0;
      contador_actualizar <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) contador_actualizar <= ~contador_actualizar;
    end
  end

  conversor_bin_bcd #(
    .ANCHO(ANCHO)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .valor   (valor),
    .valido  (valido),
    .ocupado (ocupado),
    .unidades(unidades),
    .decenas (decenas)
  );

  always_comb begin
`ifdef REFRESCO_BLANK_CEROS_EN
    if (contador_actualizar)
      digito = (decenas == 4'd0) ? BLANK_BCD : decenas;
    else
      digito = unidades;
`else
    digito = contador_actualizar ? decenas : unidades;
`endif
  end

endmodule

// File: tb/tb_refresco_display.sv
// Self-checking bench for refresco_display (ANCHO=4, DIV=4).
// Cycle-level model plus hand-computed literal checks.
module tb_refresco_display;

  localparam int ANCHO = 4;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ANCHO-1:0] valor = '0;
  logic             valido = 1'b0;
  logic             ocupado;
  logic             contador_actualizar;
  logic [3:0]       digito;

  int n_cmp = 0;
  int n_bad = 0;

  refresco_display #(
    .ANCHO(ANCHO),
    .DIV  (DIV)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .valor              (valor),
    .valido             (valido),
    .ocupado            (ocupado),
    .contador_actualizar(contador_actualizar),
    .digito             (digito)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: edges since reset, displayed value, pending conversion
  int m_edge = 0;
  bit m_busy = 0;
  int m_done = 0;
  int m_pend = 0;
  int m_shown = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge  = 0;
      m_busy  = 0;
      m_shown = 0;
    end else begin
      m_edge++;
      if (m_busy) begin
        if (m_edge == m_done) begin
          m_shown = m_pend;
          m_busy  = 0;
        end
      end else if (valido) begin
        m_busy = 1;
        m_done = m_edge + ANCHO + 1;
        m_pend = int'(valor);
      end
    end
  end

  function automatic int model_digit(input int sel, input int v);
    int t;
    t = v / 10;
    if (sel == 0) return v % 10;
`ifdef REFRESCO_BLANK_CEROS_EN
    if (t == 0) return 15;
`endif
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      int sel;
      sel = (m_edge / DIV) % 2;
      check("model_sel", int'(contador_actualizar), sel);
      check("model_ocupado", int'(ocupado), int'(m_busy));
      check("model_digito", int'(digito), model_digit(sel, m_shown));
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    valor  = ANCHO'(v);
    valido = 1'b1;
    @(negedge clk);
    valido = 1'b0;
  endtask

  // Wait (bounded) until the select shows the requested slot, at a negedge
  task automatic wait_sel(input bit s, output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (contador_actualizar == s) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_sel_timeout", 0, 1);
  endtask

  task automatic show(input string nm, input int u, input int t);
    bit ok;
    wait_sel(1'b0, ok);
    if (ok) check({nm, "_units"}, int'(digito), u);
    wait_sel(1'b1, ok);
    if (ok) check({nm, "_tens"}, int'(digito), t);
  endtask

  int tens_blank;
  bit sel_tab [12] = '{0,0,0,1,1,1,1,0,0,0,0,1};

  initial begin
`ifdef REFRESCO_BLANK_CEROS_EN
    tens_blank = 15;
`else
    tens_blank = 0;
`endif
    #12;
    check("rst_sel", int'(contador_actualizar), 0);
    check("rst_digito", int'(digito), 0);
    check("rst_ocupado", int'(ocupado), 0);
    @(negedge clk);
    rst = 1'b0;

    // Refresh: edges 1..12 after release, toggles at 4, 8, 12
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("refresh_sel", int'(contador_actualizar), int'(sel_tab[k]));
      check("refresh_digito", int'(digito), 0);
    end

    // Conversion of 13: ocupado E..E+5
    @(negedge clk);
    valor  = 4'd13;
    valido = 1'b1;
    @(negedge clk);
    valido = 1'b0;
    check("conv_ocupado_E", int'(ocupado), 1);
    repeat (4) @(negedge clk);
    check("conv_ocupado_E4", int'(ocupado), 1);
    @(negedge clk);
    check("conv_ocupado_E5", int'(ocupado), 0);
    show("conv13", 3, 1);

    send(15);
    repeat (6) @(negedge clk);
    show("conv15", 5, 1);

    // Dropped strobe: 2 at E+2 never appears
    send(9);
    @(negedge clk);
    valor  = 4'd2;
    valido = 1'b1;
    @(negedge clk);
    valido = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_ocupado", int'(ocupado), 0);
    show("drop9", 9, tens_blank);
    repeat (10) @(negedge clk);
    show("drop9_hold", 9, tens_blank);

    send(7);
    repeat (6) @(negedge clk);
    show("blank7", 7, tens_blank);

    // Reset mid-conversion after committing 12
    send(12);
    repeat (6) @(negedge clk);
    show("pre12", 2, 1);
    send(11);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ocupado", int'(ocupado), 0);
    check("mid_rst_sel", int'(contador_actualizar), 0);
    check("mid_rst_digito", int'(digito), 0);
    @(negedge clk);
    rst = 1'b0;
    show("after_rst", 0, tens_blank);
    send(6);
    repeat (6) @(negedge clk);
    show("conv6", 6, tens_blank);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
